// File: rtl/crc32_fcs_inserter.sv
// rtl/crc32_fcs_inserter.sv - streaming CRC-32 FCS appender with one-stage output register
// crc32_d8 is the MSB-first byte-wide CRC-32 step (poly 0x04C11DB7); data[7] is shifted in first.

module crc32_d8 (
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    always_comb begin
        crc_next = crc;
        for (int i = 7; i >= 0; i--) begin
            if (crc_next[31] ^ data[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ 32'h04C1_1DB7;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end
endmodule

module crc32_fcs_inserter #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] frame_cnt
);
    typedef enum logic [2:0] {PAYLOAD, FCS0, FCS1, FCS2, FCS3} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [7:0]  data_rev;
    logic        slot_free;
    logic        accept;
    logic        fcs_load;
    logic        fcs_last;
    logic [7:0]  fcs_byte;

    // Payload LSB enters the MSB-first engine first, giving the reflected Ethernet CRC.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            data_rev[7-i] = s_data[i];
        end
        for (int i = 0; i < 32; i++) begin
            fcs[31-i] = crc_q[i] ^ CRC_XOROUT[31-i];
        end
    end

    crc32_d8 u_crc (
        .crc      (crc_q),
        .data     (data_rev),
        .crc_next (crc_next)
    );

    assign slot_free = !m_valid || m_ready;
    assign s_ready   = rst_n && (state_q == PAYLOAD) && slot_free;
    assign accept    = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        fcs_load = 1'b0;
        fcs_last = 1'b0;
        fcs_byte = 8'h00;
        case (state_q)
            PAYLOAD: begin
                if (accept && s_last) state_d = FCS0;
            end
            FCS0: begin
                fcs_byte = fcs[7:0];
                if (slot_free) begin
                    fcs_load = 1'b1;
                    state_d  = FCS1;
                end
            end
            FCS1: begin
                fcs_byte = fcs[15:8];
                if (slot_free) begin
                    fcs_load = 1'b1;
                    state_d  = FCS2;
                end
            end
            FCS2: begin
                fcs_byte = fcs[23:16];
                if (slot_free) begin
                    fcs_load = 1'b1;
                    state_d  = FCS3;
                end
            end
            FCS3: begin
                fcs_byte = fcs[31:24];
                fcs_last = 1'b1;
                if (slot_free) begin
                    fcs_load = 1'b1;
                    state_d  = PAYLOAD;
                end
            end
            default: state_d = PAYLOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAYLOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            crc_q     <= CRC_INIT;
            frame_cnt <= 16'h0000;
        end else begin
            if (m_valid && m_ready && m_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (accept) begin
                m_data  <= s_data;
                m_last  <= 1'b0;
                m_valid <= 1'b1;
                crc_q   <= crc_next;
            end else if (fcs_load) begin
                m_data  <= fcs_byte;
                m_last  <= fcs_last;
                m_valid <= 1'b1;
                if (fcs_last) crc_q <= CRC_INIT;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_crc32_fcs_inserter.sv
// tb/tb_crc32_fcs_inserter.sv - randomized scoreboard bench for crc32_fcs_inserter
module tb_crc32_fcs_inserter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] frame_cnt;

    crc32_fcs_inserter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fb[$];
    logic [7:0]  stim_d[$];
    logic        stim_l[$];
    logic [7:0]  exp_d[$];
    logic        exp_l[$];
    int          pending = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic        prev_block = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int          cyc = 0;
    int          first_ho = -1;
    int          last_ho = -1;
    int          n_ho = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reflected CRC-32 over the frame buffer, as in IEEE 802.3.
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (fb[i]) begin
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic add_frame(input bit use_model);
        logic [31:0] f;
        foreach (fb[i]) begin
            stim_d.push_back(fb[i]);
            stim_l.push_back(i == fb.size() - 1);
        end
        if (use_model) begin
            f = ref_fcs();
            foreach (fb[i]) push_exp(fb[i], 1'b0);
            push_exp(f[7:0], 1'b0);
            push_exp(f[15:8], 1'b0);
            push_exp(f[23:16], 1'b0);
            push_exp(f[31:24], 1'b1);
        end
    endtask

    task automatic load_123456789();
        fb.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'h31 + 8'(i));
    endtask

    task automatic run(input int ready_pct, input int valid_pct, input int max_cyc, input bit must_finish);
        int   n = 0;
        logic acc = 1'b0;
        logic ho;
        logic sf;
        while ((stim_d.size() > 0 || exp_d.size() > 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
            cyc++;
            if (prev_block) begin
                check("hold_data", m_data, prev_data);
                check("hold_valid", m_valid, 1);
            end
            check("frame_cnt", frame_cnt, exp_cnt);
            if (!s_valid && stim_d.size() > 0 && $urandom_range(99) < valid_pct) s_valid = 1'b1;
            if (s_valid) begin
                s_data = stim_d[0];
                s_last = stim_l[0];
            end else begin
                s_data = 8'($urandom);
                s_last = 1'($urandom);
            end
            m_ready = ($urandom_range(99) < ready_pct);
            #1;
            sf = !m_valid || m_ready;
            check("s_ready", s_ready, (pending == 0) && sf);
            acc = s_valid && s_ready;
            ho  = m_valid && m_ready;
            if (ho) begin
                n_ho++;
                if (first_ho < 0) first_ho = cyc;
                last_ho = cyc;
                if (exp_d.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("m_data", m_data, exp_d[0]);
                    check("m_last", m_last, exp_l[0]);
                    if (exp_l[0]) exp_cnt++;
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            if (pending > 0 && sf) pending--;
            if (acc) begin
                if (stim_l[0]) pending = 4;
                void'(stim_d.pop_front());
                void'(stim_l.pop_front());
            end
            prev_block = m_valid && !m_ready;
            prev_data  = m_data;
            @(posedge clk);
            #1;
            if (acc) s_valid = 1'b0;
        end
        if (must_finish) check("drained", stim_d.size() + exp_d.size(), 0);
    endtask

    task automatic clear_span();
        first_ho = -1;
        last_ho  = -1;
        n_ho     = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_s_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_s_ready", s_ready, 1);

        // Known check value, full rate
        load_123456789();
        add_frame(0);
        foreach (fb[i]) push_exp(fb[i], 1'b0);
        push_exp(8'h26, 0); push_exp(8'h39, 0); push_exp(8'hF4, 0); push_exp(8'hCB, 1);
        clear_span();
        run(100, 100, 200, 1);
        check("span_123456789", last_ho - first_ho + 1, 13);
        check("beats_123456789", n_ho, 13);
        @(negedge clk);
        check("cnt_after_first", frame_cnt, 1);

        // Two back-to-back single zero-byte frames
        fb.delete();
        fb.push_back(8'h00);
        for (int k = 0; k < 2; k++) begin
            add_frame(0);
            push_exp(8'h00, 0); push_exp(8'h8D, 0); push_exp(8'hEF, 0); push_exp(8'h02, 0); push_exp(8'hD2, 1);
        end
        clear_span();
        run(100, 100, 200, 1);
        check("span_zero_pair", last_ho - first_ho + 1, 10);
        check("beats_zero_pair", n_ho, 10);

        // Check value under random backpressure
        load_123456789();
        add_frame(1);
        run(50, 100, 500, 1);

        // Random frames, random gaps and backpressure
        for (int f = 0; f < 25; f++) begin
            fb.delete();
            for (int i = 0; i < int'($urandom_range(24, 1)); i++) fb.push_back(8'($urandom));
            add_frame(1);
        end
        run(70, 70, 5000, 1);
        for (int f = 0; f < 10; f++) begin
            fb.delete();
            for (int i = 0; i < int'($urandom_range(6, 1)); i++) fb.push_back(8'($urandom));
            add_frame(1);
        end
        run(100, 100, 2000, 1);

        // Asynchronous reset after four payload bytes
        load_123456789();
        add_frame(1);
        run(100, 100, 4, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        stim_d.delete(); stim_l.delete(); exp_d.delete(); exp_l.delete();
        pending    = 0;
        prev_block = 1'b0;
        s_valid    = 1'b0;
        exp_cnt    = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        load_123456789();
        add_frame(0);
        foreach (fb[i]) push_exp(fb[i], 1'b0);
        push_exp(8'h26, 0); push_exp(8'h39, 0); push_exp(8'hF4, 0); push_exp(8'hCB, 1);
        run(100, 100, 200, 1);

        // frame_cnt wrap: preset near the top, then close two frames
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            fb.delete();
            fb.push_back(8'($urandom));
            add_frame(1);
        end
        run(100, 100, 100, 1);
        @(negedge clk);
        check("cnt_wrap", frame_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
